// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the key-event generator.
//   - KS_* : FSM state encoding (legacy-compatible 2-bit constants)
//   - HOLD_TIME / RPT_TIME : default timing, in clock cycles at 50 MHz
//   - max2 : helper used to size the shared hold/repeat counter
package key_pkg;

  localparam logic [1:0] KS_IDLE    = 2'd0;
  localparam logic [1:0] KS_PRESSED = 2'd1;
  localparam logic [1:0] KS_REPEAT  = 2'd2;

  localparam int HOLD_TIME = 25_000_000;  // 0.5 s press-to-first-repeat
  localparam int RPT_TIME  = 5_000_000;   // 0.1 s between repeats

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/level_edge_det.sv
// level_edge_det: registers the key level and flags its edges.
// Ports:
//   CLK   in   clock, posedge
//   RST   in   synchronous active-high reset
//   lvl   in   key level (already synchronous to CLK)
//   lvl_q out  lvl delayed one cycle; resets to 1 so a key held through
//              reset does not look like a fresh press
//   rise  out  lvl & ~lvl_q (combinational)
//   fall  out  ~lvl & lvl_q (combinational)
module level_edge_det (
  input  logic CLK,
  input  logic RST,
  input  logic lvl,
  output logic lvl_q,
  output logic rise,
  output logic fall
);

  // One-cycle delayed copy of the level
  always_ff @(posedge CLK) begin
    if (RST) begin
      lvl_q <= 1'b1;
    end else begin
      lvl_q <= lvl;
    end
  end

  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/key_repeat_gen.sv
// key_repeat_gen: turns a debounced key level into press, release and
// auto-repeat events.
// Parameters:
//   HOLD_TIME  cycles from press_p to the first rpt_p (>= 2)
//   RPT_TIME   cycles between successive rpt_p pulses (>= 2)
// Ports:
//   CLK      in   clock, posedge
//   RST      in   synchronous active-high reset
//   lvl      in   debounced key level, 1 = pressed
//   press_p  out  1-cycle pulse on an accepted press
//   rel_p    out  1-cycle pulse on release of an accepted press
//   rpt_p    out  1-cycle pulse per auto-repeat
//   evt_p    out  press_p | rpt_p
//   hold     out  high while in the REPEAT state
// All outputs are registered.
module key_repeat_gen #(
  parameter int HOLD_TIME = key_pkg::HOLD_TIME,
  parameter int RPT_TIME  = key_pkg::RPT_TIME
) (
  input  logic CLK,
  input  logic RST,
  input  logic lvl,
  output logic press_p,
  output logic rel_p,
  output logic rpt_p,
  output logic evt_p,
  output logic hold
);

  import key_pkg::*;

  localparam int CNTW = $clog2(max2(HOLD_TIME, RPT_TIME) + 1);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_TIME - 1);
  localparam logic [CNTW-1:0] RPT_LAST  = CNTW'(RPT_TIME - 1);
  localparam logic [CNTW-1:0] CNT_ZERO  = CNTW'(0);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

  logic            lvl_q;
  logic            rise;
  logic            fall;
  logic [1:0]      state;
  logic [1:0]      state_nx;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nx;
  logic            press_nx;
  logic            rel_nx;
  logic            rpt_nx;
  logic            hold_nx;

  level_edge_det u_edge (
    .CLK   (CLK),
    .RST   (RST),
    .lvl   (lvl),
    .lvl_q (lvl_q),
    .rise  (rise),
    .fall  (fall)
  );

  // Next-state, counter and output-pulse decode
  // PRESSED/REPEAT are only ever entered or held with lvl=1, so lvl_q is 1
  // there and "fall" is exactly "lvl=0". Release is tested before expiry so
  // it wins when both happen on the same cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = CNT_ZERO;
    press_nx = 1'b0;
    rel_nx   = 1'b0;
    rpt_nx   = 1'b0;
    hold_nx  = 1'b0;
    case (state)
      KS_IDLE: begin
        if (rise) begin
          state_nx = KS_PRESSED;
          press_nx = 1'b1;
        end else begin
          state_nx = KS_IDLE;
        end
      end
      KS_PRESSED: begin
        if (fall) begin
          state_nx = KS_IDLE;
          rel_nx   = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_nx = KS_REPEAT;
          rpt_nx   = 1'b1;
          hold_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      KS_REPEAT: begin
        if (fall) begin
          state_nx = KS_IDLE;
          rel_nx   = 1'b1;
        end else if (cnt == RPT_LAST) begin
          rpt_nx  = 1'b1;
          hold_nx = 1'b1;
        end else begin
          cnt_nx  = cnt + CNT_ONE;
          hold_nx = 1'b1;
        end
      end
      default: begin
        state_nx = KS_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= KS_IDLE;
      cnt     <= CNT_ZERO;
      press_p <= 1'b0;
      rel_p   <= 1'b0;
      rpt_p   <= 1'b0;
      evt_p   <= 1'b0;
      hold    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      press_p <= press_nx;
      rel_p   <= rel_nx;
      rpt_p   <= rpt_nx;
      evt_p   <= press_nx | rpt_nx;
      hold    <= hold_nx;
    end
  end

endmodule

// File: tb/tb_key_repeat_gen.sv
// tb_key_repeat_gen: directed scenarios plus randomized key traffic, checked
// every cycle against a behavioural model that tracks "time since press".
module tb_key_repeat_gen;

  localparam int H = 8;
  localparam int R = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic lvl = 1'b0;
  logic press_p, rel_p, rpt_p, evt_p, hold;

  int checks = 0;
  int errors = 0;

  key_repeat_gen #(.HOLD_TIME(H), .RPT_TIME(R)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .lvl     (lvl),
    .press_p (press_p),
    .rel_p   (rel_p),
    .rpt_p   (rpt_p),
    .evt_p   (evt_p),
    .hold    (hold)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Behavioural model: an accepted press starts an elapsed-cycle count e.
  // Repeats fire at e == H, H+R, H+2R, ...; hold is high once e >= H.
  bit m_valid = 1'b0;
  bit m_active = 1'b0;
  bit m_prev = 1'b1;
  int m_e = 0;
  bit e_press, e_rel, e_rpt, e_evt, e_hold;

  always @(posedge CLK) begin
    e_press = 1'b0; e_rel = 1'b0; e_rpt = 1'b0;
    if (RST) begin
      m_active = 1'b0;
      m_e = 0;
      m_prev = 1'b1;
    end else begin
      if (!m_active) begin
        if (lvl && !m_prev) begin
          e_press = 1'b1;
          m_active = 1'b1;
          m_e = 0;
        end
      end else if (!lvl) begin
        e_rel = 1'b1;
        m_active = 1'b0;
      end else begin
        m_e++;
        e_rpt = (m_e >= H) && (((m_e - H) % R) == 0);
      end
      m_prev = lvl;
    end
    e_evt = e_press | e_rpt;
    e_hold = m_active && (m_e >= H);
    m_valid = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("press_p", press_p, e_press);
      chk("rel_p", rel_p, e_rel);
      chk("rpt_p", rpt_p, e_rpt);
      chk("evt_p", evt_p, e_evt);
      chk("hold", hold, e_hold);
      chk("exclusive", (press_p & rpt_p) | (rel_p & (press_p | rpt_p)), 1'b0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    // Reset with lvl low
    RST = 1'b1; lvl = 1'b0;
    cyc(3);
    RST = 1'b0;
    cyc(2);

    // 1: short press, no repeat
    lvl = 1'b1;
    cyc(1);
    chk("t1_press", press_p, 1'b1);
    cyc(2);
    lvl = 1'b0;
    cyc(1);
    chk("t1_rel", rel_p, 1'b1);
    chk("t1_hold", hold, 1'b0);
    cyc(3);

    // 2: long hold, literal timing of press and repeats
    lvl = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      cyc(1);
      chk("t2_press", press_p, (t == 1) ? 1'b1 : 1'b0);
      chk("t2_rpt", rpt_p, (t == 9 || t == 13 || t == 17) ? 1'b1 : 1'b0);
      chk("t2_evt", evt_p, (t == 1 || t == 9 || t == 13 || t == 17) ? 1'b1 : 1'b0);
      chk("t2_hold", hold, (t >= 9) ? 1'b1 : 1'b0);
    end
    lvl = 1'b0;
    cyc(1);
    chk("t2_rel", rel_p, 1'b1);
    chk("t2_hold_off", hold, 1'b0);
    cyc(3);

    // 3: release lands on the cycle the hold counter expires
    lvl = 1'b1;
    for (int t = 1; t <= H; t++) begin
      cyc(1);
      if (t == H) lvl = 1'b0;
    end
    cyc(1);
    chk("t3_rel", rel_p, 1'b1);
    chk("t3_rpt", rpt_p, 1'b0);
    chk("t3_hold", hold, 1'b0);
    cyc(1);
    chk("t3_idle_rel", rel_p, 1'b0);
    chk("t3_idle_press", press_p, 1'b0);
    cyc(2);

    // 4: key held across reset deassert
    lvl = 1'b1;
    RST = 1'b1;
    cyc(2);
    RST = 1'b0;
    cyc(1);
    chk("t4_no_press", press_p, 1'b0);
    cyc(5);
    lvl = 1'b0;
    cyc(1);
    chk("t4_no_rel", rel_p, 1'b0);
    cyc(2);
    lvl = 1'b1;
    cyc(1);
    chk("t4_press", press_p, 1'b1);
    cyc(3);
    lvl = 1'b0;
    cyc(3);

    // 5: reset pulsed while repeating
    lvl = 1'b1;
    cyc(12);
    chk("t5_in_repeat", hold, 1'b1);
    RST = 1'b1;
    cyc(1);
    chk("t5_hold", hold, 1'b0);
    chk("t5_rel", rel_p, 1'b0);
    chk("t5_rpt", rpt_p, 1'b0);
    chk("t5_evt", evt_p, 1'b0);
    RST = 1'b0;
    cyc(2);
    lvl = 1'b0;
    cyc(1);
    chk("t5_no_rel", rel_p, 1'b0);
    cyc(2);

    // 6: back-to-back single-cycle glitches
    for (int g = 0; g < 4; g++) begin
      lvl = 1'b1;
      cyc(1);
      chk("t6_press", press_p, 1'b1);
      lvl = 1'b0;
      cyc(1);
      chk("t6_rel", rel_p, 1'b1);
    end
    cyc(2);

    // Randomized traffic: level runs of varied length, occasional reset
    for (int s = 0; s < 300; s++) begin
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
      end
      cyc($urandom_range(1, 22));
    end
    lvl = 1'b0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
